// File: rtl/out_ram_reader.sv
// out_ram_reader: drains the multiplier's output RAM after a computation pass.
// Reads addresses 0..NUM_WORDS-1 in order (one registered RAM read per word),
// presents each word on a valid/ready stream, then pulses done and goes idle.
// All stream/RAM control outputs decode from the state and index registers,
// so nothing on the outputs depends combinationally on an input.
module out_ram_reader #(
  parameter int ADDR_WIDTH = 3,
  parameter int DATA_WIDTH = 32,
  parameter int NUM_WORDS  = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  output logic                  rd_en,
  output logic [ADDR_WIDTH-1:0] rd_addr,
  input  logic [DATA_WIDTH-1:0] rd_data,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  out_last,
  output logic                  busy,
  output logic                  done
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ISSUE = 3'd1,
    WAIT  = 3'd2,
    SEND  = 3'd3,
    DONE  = 3'd4
  } state_t;

  // Index of the final word of a pass, in the counter's own width.
  localparam logic [ADDR_WIDTH:0] LAST_IDX = (ADDR_WIDTH + 1)'(NUM_WORDS - 1);
  localparam logic [ADDR_WIDTH:0] IDX_ONE  = (ADDR_WIDTH + 1)'(1);

  state_t              state;
  state_t              state_next;
  logic [ADDR_WIDTH:0] idx;
  logic [ADDR_WIDTH:0] idx_next;
  logic                is_last;

  assign is_last = (idx == LAST_IDX);

  // State and word-counter registers; reset aborts any pass in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      idx   <= '0;
    end else begin
      state <= state_next;
      idx   <= idx_next;
    end
  end

  // Capture RAM read data in WAIT (data is valid the cycle after rd_en) and
  // hold it through SEND so the stream word stays stable under backpressure.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_data <= '0;
    end else if (state == WAIT) begin
      out_data <= rd_data;
    end else begin
      out_data <= out_data;
    end
  end

  // Next-state and counter logic; start is only looked at in IDLE.
  always_comb begin
    state_next = state;
    idx_next   = idx;
    case (state)
      IDLE: begin
        idx_next = '0;
        if (start) begin
          state_next = ISSUE;
        end else begin
          state_next = IDLE;
        end
      end
      ISSUE: begin
        state_next = WAIT;
      end
      WAIT: begin
        state_next = SEND;
      end
      SEND: begin
        if (out_ready && is_last) begin
          state_next = DONE;
        end else if (out_ready) begin
          idx_next   = idx + IDX_ONE;
          state_next = ISSUE;
        end else begin
          state_next = SEND;
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
        idx_next   = '0;
      end
    endcase
  end

  // Output decode from registered state/index only; rd_addr is zero outside ISSUE.
  always_comb begin
    rd_en     = 1'b0;
    rd_addr   = '0;
    out_valid = 1'b0;
    out_last  = 1'b0;
    busy      = 1'b1;
    done      = 1'b0;
    case (state)
      IDLE: begin
        busy = 1'b0;
      end
      ISSUE: begin
        rd_en   = 1'b1;
        rd_addr = idx[ADDR_WIDTH-1:0];
      end
      WAIT: begin
        rd_en = 1'b0;
      end
      SEND: begin
        out_valid = 1'b1;
        out_last  = is_last;
      end
      DONE: begin
        done = 1'b1;
      end
      default: begin
        busy = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_out_ram_reader.sv
// Testbench for out_ram_reader: a cycle table derived from the pass timing
// formulas, hand-written backpressure/start/reset sequences, and a randomized
// continuous-start run, all checked by a stream-level reference model.
module tb_out_ram_reader;

  localparam int AW = 3;
  localparam int DW = 32;
  localparam int NW = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic          rd_en;
  logic [AW-1:0] rd_addr;
  logic [DW-1:0] rd_data;
  logic [DW-1:0] out_data;
  logic          out_valid;
  logic          out_ready;
  logic          out_last;
  logic          busy;
  logic          done;

  logic [DW-1:0] mem [NW];

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model state: next expected read address, next expected word.
  int   exp_addr  = 0;
  int   exp_word  = 0;
  int   done_cnt  = 0;
  int   hs_total  = 0;
  logic done_due  = 1'b0;
  logic p_rst     = 1'b0;
  logic p_valid   = 1'b0;
  logic p_ready   = 1'b0;
  logic p_busy    = 1'b0;
  logic p_start   = 1'b0;
  logic p_done    = 1'b0;
  logic p_last    = 1'b0;
  logic [DW-1:0] p_data = '0;

  typedef struct {
    logic          s;
    logic          r;
    logic          en;
    logic [AW-1:0] addr;
    logic          v;
    logic          l;
    logic          b;
    logic          d;
    logic [DW-1:0] data;
  } vec_t;

  vec_t tbl [28];

  always #5 clk = ~clk;

  out_ram_reader #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_WORDS(NW)) dut (
    .clk(clk), .rst(rst), .start(start),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_last(out_last), .busy(busy), .done(done)
  );

  // Output RAM model: registered read; junk on the bus when not reading.
  always @(posedge clk) begin
    if (rd_en) rd_data <= mem[rd_addr];
    else       rd_data <= $urandom;
  end

  task automatic check(input string name, input logic ok,
                       input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (ok) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Stream-level checks for the current cycle, then model update.
  task automatic monitor();
    if (p_rst) begin
      check("reset_state", {rd_en, rd_addr, out_valid, out_last, busy, done, out_data} == '0,
            {24'd0, rd_en, rd_addr, out_valid, out_last, busy, done, out_data}, 64'd0);
    end else begin
      if (rd_en) begin
        check("rd_addr", rd_addr == exp_addr[AW-1:0], 64'(rd_addr), 64'(exp_addr));
        exp_addr = (exp_addr + 1) % NW;
      end else begin
        check("rd_addr_idle", rd_addr == '0, 64'(rd_addr), 64'd0);
      end
      check("rd_en_only_issue", !rd_en || (busy && !out_valid && !done),
            {60'd0, rd_en, busy, out_valid, done}, {60'd0, rd_en, 1'b1, 1'b0, 1'b0});
      if (!p_busy && p_start)
        check("start_latency", rd_en && busy, {62'd0, rd_en, busy}, 64'd3);
      if (!p_busy && !p_start)
        check("idle_stays", !busy && !rd_en, {62'd0, rd_en, busy}, 64'd0);
      if (p_done)
        check("busy_falls", !busy, 64'(busy), 64'd0);
      if (p_valid && !p_ready)
        check("hold_stable", out_valid && out_data == p_data && out_last == p_last,
              {31'd0, out_valid, out_data}, {31'd0, 1'b1, p_data});
      check("done", done == done_due, 64'(done), 64'(done_due));
      if (done) done_cnt++;
      done_due = 1'b0;
      if (out_valid && out_ready) begin
        check("data", out_data == mem[exp_word], 64'(out_data), 64'(mem[exp_word]));
        check("last", out_last == (exp_word == NW - 1), 64'(out_last), 64'(exp_word == NW - 1));
        hs_total++;
        if (exp_word == NW - 1) begin
          done_due = 1'b1;
          exp_word = 0;
        end else begin
          exp_word++;
        end
      end
    end
    p_rst   = rst;
    p_valid = out_valid;
    p_ready = out_ready;
    p_data  = out_data;
    p_last  = out_last;
    p_busy  = busy;
    p_start = start;
    p_done  = done;
    if (rst) begin
      exp_addr = 0;
      exp_word = 0;
      done_due = 1'b0;
    end
  endtask

  task automatic step(input logic s, input logic r, input logic rs);
    start     = s;
    out_ready = r;
    rst       = rs;
    monitor();
  endtask

  task automatic tick(input logic s, input logic r, input logic rs);
    @(negedge clk);
    step(s, r, rs);
  endtask

  // Run until a done pulse with the given start level; ready random or high.
  task automatic wait_done(input int max_cyc, input logic rnd, input logic s);
    int d0;
    d0 = done_cnt;
    for (int i = 0; i < max_cyc && done_cnt == d0; i++)
      tick(s, rnd ? 1'($urandom_range(0, 1)) : 1'b1, 1'b0);
    check("done_timeout", done_cnt == d0 + 1, 64'(done_cnt - d0), 64'd1);
  endtask

  initial begin
    int d0;
    int h0;
    logic found;

    for (int i = 0; i < NW; i++) mem[i] = 32'h1000_0000 + 32'(i);

    // Cycle table for one pass with ready held high; start sampled in cycle 0.
    for (int c = 0; c < 28; c++) begin
      tbl[c] = '{s: (c == 0), r: 1'b1, en: 1'b0, addr: '0, v: 1'b0, l: 1'b0,
                 b: 1'b0, d: 1'b0, data: '0};
      if (c >= 1 && c <= 24) begin
        int k;
        int ph;
        k = (c - 1) / 3;
        ph = (c - 1) % 3;
        tbl[c].b    = 1'b1;
        tbl[c].en   = (ph == 0);
        tbl[c].addr = (ph == 0) ? AW'(k) : '0;
        tbl[c].v    = (ph == 2);
        tbl[c].l    = (ph == 2) && (k == NW - 1);
        tbl[c].data = 32'h1000_0000 + 32'(k);
      end else if (c == 25) begin
        tbl[c].b = 1'b1;
        tbl[c].d = 1'b1;
      end
    end

    rst = 1'b1; start = 1'b0; out_ready = 1'b0;
    repeat (2) @(negedge clk);
    p_rst = 1'b1;
    tick(1'b0, 1'b0, 1'b0);
    tick(1'b0, 1'b1, 1'b0);

    // Basic drain via the cycle table.
    d0 = done_cnt;
    for (int i = 0; i < 28; i++) begin
      tick(tbl[i].s, tbl[i].r, 1'b0);
      check($sformatf("vec%0d", i),
            ({rd_en, rd_addr, out_valid, out_last, busy, done} ==
             {tbl[i].en, tbl[i].addr, tbl[i].v, tbl[i].l, tbl[i].b, tbl[i].d}) &&
            (!tbl[i].v || out_data == tbl[i].data),
            {24'd0, rd_en, rd_addr, out_valid, out_last, busy, done, out_data},
            {24'd0, tbl[i].en, tbl[i].addr, tbl[i].v, tbl[i].l, tbl[i].b, tbl[i].d,
             tbl[i].v ? tbl[i].data : out_data});
    end
    check("basic_one_done", done_cnt == d0 + 1, 64'(done_cnt - d0), 64'd1);

    // Backpressure: ready low for 5 cycles while word 3 is presented.
    tick(1'b1, 1'b1, 1'b0);
    found = 1'b0;
    for (int i = 0; i < 60 && !found; i++) begin
      @(negedge clk);
      if (out_valid && exp_word == 3) found = 1'b1;
      step(1'b0, !found, 1'b0);
    end
    check("bp_reach", found, 64'(found), 64'd1);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("bp_hold_word3", out_valid && out_data == 32'h1000_0003,
            {31'd0, out_valid, out_data}, {31'd0, 1'b1, 32'h1000_0003});
      step(1'b0, 1'b0, 1'b0);
    end
    wait_done(60, 1'b0, 1'b0);

    // Start pulses while busy are ignored.
    d0 = done_cnt; h0 = hs_total;
    tick(1'b1, 1'b1, 1'b0);
    for (int c = 1; c < 34; c++) tick((c == 4) || (c == 10), 1'b1, 1'b0);
    check("busy_start_done", done_cnt == d0 + 1, 64'(done_cnt - d0), 64'd1);
    check("busy_start_words", hs_total == h0 + NW, 64'(hs_total - h0), 64'(NW));

    // Reset during the SEND of word 4 aborts the pass.
    tick(1'b1, 1'b1, 1'b0);
    found = 1'b0;
    for (int i = 0; i < 60 && !found; i++) begin
      @(negedge clk);
      if (out_valid && exp_word == 4) found = 1'b1;
      step(1'b0, !found, found);
    end
    check("rst_reach", found, 64'(found), 64'd1);
    d0 = done_cnt; h0 = hs_total;
    for (int i = 0; i < 6; i++) tick(1'b0, 1'b1, 1'b0);
    check("rst_no_done", done_cnt == d0, 64'(done_cnt - d0), 64'd0);
    check("rst_no_words", hs_total == h0, 64'(hs_total - h0), 64'd0);
    tick(1'b1, 1'b1, 1'b0);
    wait_done(60, 1'b0, 1'b0);
    check("rst_fresh_pass", hs_total == h0 + NW, 64'(hs_total - h0), 64'(NW));

    // Continuous start with random ready and random RAM contents.
    for (int i = 0; i < NW; i++) mem[i] = $urandom;
    d0 = done_cnt; h0 = hs_total;
    for (int i = 0; i < 400 && done_cnt < d0 + 3; i++)
      tick(1'b1, 1'($urandom_range(0, 1)), 1'b0);
    check("cont_passes", done_cnt == d0 + 3, 64'(done_cnt - d0), 64'd3);
    check("cont_words", hs_total == h0 + 3 * NW, 64'(hs_total - h0), 64'(3 * NW));
    for (int i = 0; i < 5; i++) tick(1'b0, 1'($urandom_range(0, 1)), 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
